spi_reg_ctrl: RTL and testbench
===============================

# spi_reg_ctrl

Command sequencer on the byte side of `SPI_slave`: frames each `ssel`-low transaction, decodes a command byte, and turns it into register reads/writes on a simple req/ack bus. It supplies `dataToSend` whenever the slave raises `dataNeeded`. It sits between `SPI_slave` and the on-chip register space, so an external SPI master can peek and poke FPGA registers.

## Interface
- `TIMEOUT`, 15: bus cycles to wait for `bus_ack` before aborting (1..255).
- `STATUS_BYTE`, 8'hA5: byte shifted out while the command byte is received.
- `ERR_BYTE`, 8'hEE: byte shifted out when read data is not ready.
- `clk` in 1: system clock, the same clock as `SPI_slave`.
- `rst` in 1: synchronous, active-high reset.
- `ssel` in 1: raw SPI chip select, active low; double-flopped internally.
- `byteReceived` in 1: one-cycle pulse from `SPI_slave`.
- `receivedData` in 8: byte valid while `byteReceived` is high.
- `dataNeeded` in 1: one-cycle pulse; `SPI_slave` samples `dataToSend` in this cycle.
- `dataToSend` out 8: next byte to shift out on MISO.
- `bus_req` out 1: bus request, held until ack or timeout.
- `bus_we` out 1: 1 = write, 0 = read.
- `bus_addr` out 7: register address.
- `bus_wdata` out 8: write data.
- `bus_rdata` in 8: read data, valid with `bus_ack`.
- `bus_ack` in 1: one-cycle completion pulse.
- `err` out 1: sticky error (timeout or read underrun); cleared by `rst` or by the next `ssel` falling edge.

## Operation
- Frame: synced `ssel` falling edge → CMD; synced `ssel` high → IDLE, once any outstanding bus request has completed.
- Command byte: bit7 = rw (1 = read), bits 6:0 = addr.
- Write: the byte after the command is issued as a bus write to addr.
- Read:
  - A bus read to addr is issued in the cycle after the command's `byteReceived`.
  - The returned data is latched into `dataToSend`.
- Extra bytes:
  - With auto-increment, each further byte writes or reads addr+1.
  - Without it, further bytes are ignored and `dataToSend` = `STATUS_BYTE`.
- States:
  - IDLE → CMD on frame start.
  - CMD → WDATA (write) or RD_WAIT (read) on `byteReceived`.
  - WDATA → WR_WAIT on `byteReceived`; `bus_req` is raised.
  - WR_WAIT → WDATA (autoinc) or DISCARD on `bus_ack`.
  - RD_WAIT → RD_READY on `bus_ack`.
  - RD_READY → RD_WAIT (autoinc, prefetch addr+1) or DISCARD on the `dataNeeded` that consumes the data.
  - Any waiting state → DISCARD on timeout, with `err` set.
  - DISCARD → IDLE on frame end.
- Read underrun: `dataNeeded` arrives in RD_WAIT → `dataToSend` = `ERR_BYTE` and `err` is set. The read still completes; its data is dropped.
- Address arithmetic is 7-bit and wraps 0x7F → 0x00.
- `byteReceived` in IDLE or DISCARD is ignored.
- `byteReceived` and `bus_ack` in the same cycle: the ack is processed first, and the byte is taken as the next write data.

## Timing
- Reset values:
  - `dataToSend` = `STATUS_BYTE`
  - `bus_req` = 0, `bus_we` = 0, `bus_addr` = 0, `bus_wdata` = 0
  - `err` = 0
  - state = IDLE
- `ssel` has 2 cycles of sync latency; the frame-start edge is detected in cycle 3 after the pin falls.
- `bus_req` rises 1 cycle after the triggering `byteReceived`.
- `bus_addr`, `bus_we` and `bus_wdata` are stable while `bus_req` is high.
- `bus_req` falls in the cycle after `bus_ack`.
- Read data appears on `dataToSend` 1 cycle after `bus_ack`.
- Timeout: a counter starts at `bus_req` rise and fires when TIMEOUT cycles pass without ack. `bus_req` drops the next cycle.
- `rst` mid-transaction drops `bus_req` immediately. The bus slave must tolerate an abandoned request.
- Frame end mid-request: `bus_req` stays high until ack or timeout, then the block goes to IDLE.

## Configuration
- `SPI_REG_CTRL_AUTOINC_EN` defined: burst mode. Consecutive bytes address addr, addr+1, … with wrap, and reads prefetch the next address.
- Not defined: exactly one register access per frame. Later bytes go to DISCARD behaviour.

## Structure
- Package `spi_reg_pkg`:
  - state enum
  - `STATUS_BYTE` / `ERR_BYTE` defaults
  - command field constants (RW bit index, ADDR_W = 7)
- Sub-module `ssel_sync`: 2-flop synchronizer with falling- and rising-edge pulse outputs. Everything else is in one module.

## Test plan
- Write: frame with 0x05, 0x3C, bus acks after 2 cycles → one request with `bus_we`=1, `bus_addr`=0x05, `bus_wdata`=0x3C; `err`=0.
- Read: 0x85, dummy byte, `bus_rdata`=0x5A acked after 3 cycles → MISO carries 0xA5 then 0x5A.
- Burst (`SPI_REG_CTRL_AUTOINC_EN`): write 0x7F, bytes 0x11 0x22 → writes to 0x7F then 0x00; without the macro, only 0x7F is written.
- Timeout: read 0x81, `bus_ack` never asserted → `bus_req` drops after 15 cycles, `err`=1, next MISO byte 0xEE.
- Underrun: ack delayed past `dataNeeded` → MISO 0xEE, `err`=1; a new frame clears `err`.
- Abort: `ssel` raised between command and data bytes of a write → no bus request; IDLE; the next frame works normally.

Source files
------------

// File: rtl/spi_reg_pkg.sv
// Shared types and constants for the SPI register controller.
// Holds the FSM state encoding, the default MISO status and error bytes,
// command-byte field layout, the bus request payload and address increment.
package spi_reg_pkg;

  localparam int unsigned DATA_W     = 8;
  localparam int unsigned ADDR_W     = 7;
  localparam int unsigned CMD_RW_BIT = 7;
  localparam int unsigned TMO_W      = 8;

  localparam logic [DATA_W-1:0] STATUS_BYTE_DEF = 8'hA5;
  localparam logic [DATA_W-1:0] ERR_BYTE_DEF    = 8'hEE;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CMD      = 3'd1,
    ST_WDATA    = 3'd2,
    ST_WR_WAIT  = 3'd3,
    ST_RD_WAIT  = 3'd4,
    ST_RD_READY = 3'd5,
    ST_DISCARD  = 3'd6
  } state_e;

  // Payload presented on the register bus while bus_req is high.
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } bus_cmd_t;

  // 7-bit address increment, wraps 0x7F -> 0x00.
  function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
    return a + ADDR_W'(1);
  endfunction

endpackage

// File: rtl/ssel_sync.sv
// Two-flop synchronizer for the raw SPI chip select plus edge detection.
// Ports:
//   clk, rst  : system clock, synchronous active-high reset
//   ssel_i    : raw chip select pin (active low)
//   ssel_o    : synchronized level
//   fall_c    : one-cycle pulse on synchronized falling edge (frame start)
//   rise_c    : one-cycle pulse on synchronized rising edge (frame end)
module ssel_sync (
  input  logic clk,
  input  logic rst,
  input  logic ssel_i,
  output logic ssel_o,
  output logic fall_c,
  output logic rise_c
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Reset to deselected so no spurious edge comes out of reset with ssel high.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= ssel_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign ssel_o = sync_q;
  assign fall_c = prev_q & ~sync_q;
  assign rise_c = ~prev_q & sync_q;

endmodule

// File: rtl/spi_reg_ctrl.sv
// Command sequencer between SPI_slave's byte interface and a req/ack
// register bus. Each ssel-low frame carries a command byte
// (bit7 = read, bits 6:0 = address) followed by write data or dummy bytes
// that clock read data out on MISO.
// Build option: SPI_REG_CTRL_AUTOINC_EN enables burst access with
// address auto-increment and read prefetch; otherwise one access per frame.
// Ports:
//   clk, rst                    : system clock, synchronous active-high reset
//   ssel                        : raw chip select, active low
//   byteReceived, receivedData  : received byte strobe and value
//   dataNeeded, dataToSend      : MISO byte request strobe and byte
//   bus_req/we/addr/wdata       : register bus request
//   bus_rdata, bus_ack          : register bus response
//   err                         : sticky error (timeout or read underrun)
module spi_reg_ctrl
  import spi_reg_pkg::*;
#(
  parameter int unsigned       TIMEOUT     = 15,
  parameter logic [DATA_W-1:0] STATUS_BYTE = STATUS_BYTE_DEF,
  parameter logic [DATA_W-1:0] ERR_BYTE    = ERR_BYTE_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ssel,
  input  logic              byteReceived,
  input  logic [DATA_W-1:0] receivedData,
  input  logic              dataNeeded,
  output logic [DATA_W-1:0] dataToSend,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_ack,
  output logic              err
);

`ifdef SPI_REG_CTRL_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  logic ssel_hi;
  logic ssel_fall_c;
  logic ssel_rise_c;

  ssel_sync u_ssel_sync (
    .clk    (clk),
    .rst    (rst),
    .ssel_i (ssel),
    .ssel_o (ssel_hi),
    .fall_c (ssel_fall_c),
    .rise_c (ssel_rise_c)
  );

  state_e            state_q,    state_d;
  logic [ADDR_W-1:0] addr_q,     addr_d;
  logic [DATA_W-1:0] tx_q,       tx_d;
  logic              req_q,      req_d;
  bus_cmd_t          cmd_q,      cmd_d;
  logic              err_q,      err_d;
  logic              drop_q,     drop_d;
  logic [DATA_W-1:0] wbuf_q,     wbuf_d;
  logic              wbuf_vld_q, wbuf_vld_d;
  logic              end_pend_q, end_pend_d;
  logic [TMO_W-1:0]  tmo_cnt_q,  tmo_cnt_d;

  logic ack_c;
  logic tmo_c;
  logic frame_end_c;

  // Next-state and datapath logic.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    tx_d       = tx_q;
    req_d      = req_q;
    cmd_d      = cmd_q;
    err_d      = err_q;
    drop_d     = drop_q;
    wbuf_d     = wbuf_q;
    wbuf_vld_d = wbuf_vld_q;
    // A short ssel bounce during a bus wait must still end the frame.
    end_pend_d = end_pend_q | ssel_rise_c;

    // Counter runs only while a request is outstanding; it is zero at req rise.
    tmo_cnt_d   = req_q ? tmo_cnt_q + TMO_W'(1) : '0;
    ack_c       = req_q & bus_ack;
    tmo_c       = req_q & ~bus_ack & (tmo_cnt_q == TMO_W'(TIMEOUT - 1));
    frame_end_c = ssel_hi | end_pend_q;

    if (ack_c || tmo_c) begin
      req_d = 1'b0;
    end

    if (ssel_fall_c) begin
      err_d = 1'b0;
    end

    unique case (state_q)
      ST_IDLE: begin
        end_pend_d = 1'b0;
        drop_d     = 1'b0;
        wbuf_vld_d = 1'b0;
        if (ssel_fall_c) begin
          tx_d    = STATUS_BYTE;
          state_d = ST_CMD;
        end
      end

      ST_CMD: begin
        if (frame_end_c) begin
          state_d = ST_IDLE;
        end else if (byteReceived) begin
          addr_d = receivedData[ADDR_W-1:0];
          if (receivedData[CMD_RW_BIT]) begin
            // Until read data lands, any MISO byte taken is an underrun.
            req_d      = 1'b1;
            cmd_d.we   = 1'b0;
            cmd_d.addr = receivedData[ADDR_W-1:0];
            tx_d       = ERR_BYTE;
            drop_d     = 1'b0;
            state_d    = ST_RD_WAIT;
          end else begin
            state_d = ST_WDATA;
          end
        end
      end

      ST_WDATA: begin
        if (frame_end_c) begin
          state_d = ST_IDLE;
        end else if (wbuf_vld_q || byteReceived) begin
          // A byte buffered during the previous write goes out first.
          req_d       = 1'b1;
          cmd_d.we    = 1'b1;
          cmd_d.addr  = addr_q;
          cmd_d.wdata = wbuf_vld_q ? wbuf_q : receivedData;
          wbuf_vld_d  = 1'b0;
          state_d     = ST_WR_WAIT;
        end
      end

      ST_WR_WAIT: begin
        if (AUTOINC && byteReceived) begin
          wbuf_d     = receivedData;
          wbuf_vld_d = 1'b1;
        end
        if (ack_c || tmo_c) begin
          if (frame_end_c) begin
            state_d = ST_IDLE;
          end else if (tmo_c) begin
            err_d      = 1'b1;
            wbuf_vld_d = 1'b0;
            state_d    = ST_DISCARD;
          end else if (AUTOINC) begin
            addr_d  = addr_inc(addr_q);
            state_d = ST_WDATA;
          end else begin
            state_d = ST_DISCARD;
          end
        end
      end

      ST_RD_WAIT: begin
        if (dataNeeded) begin
          err_d  = 1'b1;
          drop_d = 1'b1;
        end
        if (ack_c || tmo_c) begin
          if (tmo_c) begin
            err_d = 1'b1;
          end
          if (frame_end_c) begin
            state_d = ST_IDLE;
          end else if (tmo_c) begin
            state_d = ST_DISCARD;
          end else if (drop_q || dataNeeded) begin
            tx_d    = STATUS_BYTE;
            state_d = ST_DISCARD;
          end else begin
            tx_d    = bus_rdata;
            state_d = ST_RD_READY;
          end
        end
      end

      ST_RD_READY: begin
        if (frame_end_c) begin
          state_d = ST_IDLE;
        end else if (dataNeeded) begin
          if (AUTOINC) begin
            addr_d     = addr_inc(addr_q);
            req_d      = 1'b1;
            cmd_d.we   = 1'b0;
            cmd_d.addr = addr_inc(addr_q);
            tx_d       = ERR_BYTE;
            drop_d     = 1'b0;
            state_d    = ST_RD_WAIT;
          end else begin
            tx_d    = STATUS_BYTE;
            state_d = ST_DISCARD;
          end
        end
      end

      ST_DISCARD: begin
        if (frame_end_c) begin
          state_d = ST_IDLE;
        end else if (dataNeeded) begin
          tx_d = STATUS_BYTE;
        end
      end

      default: begin
        req_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      tx_q       <= STATUS_BYTE;
      req_q      <= 1'b0;
      cmd_q      <= '0;
      err_q      <= 1'b0;
      drop_q     <= 1'b0;
      wbuf_q     <= '0;
      wbuf_vld_q <= 1'b0;
      end_pend_q <= 1'b0;
      tmo_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      tx_q       <= tx_d;
      req_q      <= req_d;
      cmd_q      <= cmd_d;
      err_q      <= err_d;
      drop_q     <= drop_d;
      wbuf_q     <= wbuf_d;
      wbuf_vld_q <= wbuf_vld_d;
      end_pend_q <= end_pend_d;
      tmo_cnt_q  <= tmo_cnt_d;
    end
  end

  assign dataToSend = tx_q;
  assign bus_req    = req_q;
  assign bus_we     = cmd_q.we;
  assign bus_addr   = cmd_q.addr;
  assign bus_wdata  = cmd_q.wdata;
  assign err        = err_q;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Directed bench for spi_reg_ctrl: drives SPI byte strobes and a bus
// responder with programmable ack latency, checks MISO bytes, bus requests
// and the error flag against hand-computed values.
module tb_spi_reg_ctrl;

`ifdef SPI_REG_CTRL_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       ssel;
  logic       byteReceived;
  logic [7:0] receivedData;
  logic       dataNeeded;
  logic [7:0] dataToSend;
  logic       bus_req;
  logic       bus_we;
  logic [6:0] bus_addr;
  logic [7:0] bus_wdata;
  logic [7:0] bus_rdata;
  logic       bus_ack;
  logic       err;

  always #5 clk = ~clk;

  spi_reg_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .ssel         (ssel),
    .byteReceived (byteReceived),
    .receivedData (receivedData),
    .dataNeeded   (dataNeeded),
    .dataToSend   (dataToSend),
    .bus_req      (bus_req),
    .bus_we       (bus_we),
    .bus_addr     (bus_addr),
    .bus_wdata    (bus_wdata),
    .bus_rdata    (bus_rdata),
    .bus_ack      (bus_ack),
    .err          (err)
  );

  int n_chk = 0;
  int n_bad = 0;

  // Bus responder configuration and request log.
  bit         ack_en  = 1'b1;
  int         ack_dly = 2;
  logic [7:0] rd_val  = 8'h00;
  int         nreq    = 0;
  int         req_hi  = 0;
  logic       log_we    [32];
  logic [6:0] log_addr  [32];
  logic [7:0] log_wdata [32];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Bus slave: logs each new request, acks after ack_dly cycles of bus_req.
  initial begin
    int cnt;
    bit busy;
    cnt       = 0;
    busy      = 1'b0;
    bus_ack   = 1'b0;
    bus_rdata = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      bus_ack = 1'b0;
      if (rst) begin
        busy = 1'b0;
      end else if (bus_req) begin
        req_hi++;
        if (!busy) begin
          busy = 1'b1;
          cnt  = 0;
          if (nreq < 32) begin
            log_we[nreq]    = bus_we;
            log_addr[nreq]  = bus_addr;
            log_wdata[nreq] = bus_wdata;
          end
          nreq++;
        end
        cnt++;
        if (ack_en && cnt == ack_dly) begin
          bus_ack   = 1'b1;
          bus_rdata = rd_val;
        end
      end else begin
        busy = 1'b0;
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic frame_begin();
    ssel = 1'b0;
    cycles(4);
  endtask

  task automatic frame_end();
    ssel = 1'b1;
    cycles(6);
  endtask

  // One SPI byte: MISO sampled on dataNeeded, MOSI delivered a few cycles later.
  task automatic spi_xfer(input logic [7:0] mosi, input logic [7:0] miso_exp,
                          input string tag, input int pre);
    cycles(pre);
    dataNeeded = 1'b1;
    @(negedge clk);
    chk(tag, 32'(dataToSend), 32'(miso_exp));
    @(posedge clk);
    #1;
    dataNeeded = 1'b0;
    cycles(3);
    receivedData = mosi;
    byteReceived = 1'b1;
    @(posedge clk);
    #1;
    byteReceived = 1'b0;
  endtask

  initial begin
    int b;
    rst          = 1'b1;
    ssel         = 1'b1;
    byteReceived = 1'b0;
    receivedData = 8'h00;
    dataNeeded   = 1'b0;
    cycles(3);

    chk("rst_miso",  32'(dataToSend), 32'h0000_00A5);
    chk("rst_req",   32'(bus_req),    32'h0);
    chk("rst_we",    32'(bus_we),     32'h0);
    chk("rst_addr",  32'(bus_addr),   32'h0);
    chk("rst_wdata", 32'(bus_wdata),  32'h0);
    chk("rst_err",   32'(err),        32'h0);
    rst = 1'b0;
    cycles(4);

    // Single write 0x3C to 0x05.
    b = nreq;
    ack_dly = 2;
    frame_begin();
    spi_xfer(8'h05, 8'hA5, "wr_miso0", 0);
    spi_xfer(8'h3C, 8'hA5, "wr_miso1", 0);
    cycles(6);
    chk("wr_nreq",  32'(nreq - b),    32'd1);
    chk("wr_we",    32'(log_we[b]),   32'h1);
    chk("wr_addr",  32'(log_addr[b]), 32'h05);
    chk("wr_wdata", 32'(log_wdata[b]), 32'h3C);
    chk("wr_err",   32'(err),         32'h0);
    frame_end();

    // Read 0x05 returning 0x5A after 3 cycles.
    b = nreq;
    ack_dly = 3;
    rd_val  = 8'h5A;
    frame_begin();
    spi_xfer(8'h85, 8'hA5, "rd_miso0", 0);
    spi_xfer(8'h00, 8'h5A, "rd_miso1", 8);
    cycles(6);
    chk("rd_nreq", 32'(nreq - b),    AUTOINC ? 32'd2 : 32'd1);
    chk("rd_we",   32'(log_we[b]),   32'h0);
    chk("rd_addr", 32'(log_addr[b]), 32'h05);
    chk("rd_err",  32'(err),         32'h0);
    frame_end();

    // Burst write at 0x7F: second byte wraps to 0x00 only with auto-increment.
    b = nreq;
    ack_dly = 2;
    frame_begin();
    spi_xfer(8'h7F, 8'hA5, "bw_miso0", 0);
    spi_xfer(8'h11, 8'hA5, "bw_miso1", 0);
    spi_xfer(8'h22, 8'hA5, "bw_miso2", 6);
    cycles(6);
    chk("bw_nreq",   32'(nreq - b),     AUTOINC ? 32'd2 : 32'd1);
    chk("bw_addr0",  32'(log_addr[b]),  32'h7F);
    chk("bw_wdata0", 32'(log_wdata[b]), 32'h11);
    if (AUTOINC) begin
      chk("bw_addr1",  32'(log_addr[b+1]),  32'h00);
      chk("bw_wdata1", 32'(log_wdata[b+1]), 32'h22);
    end
    frame_end();

    // Read with no ack: request held exactly 15 cycles, then error byte.
    b = nreq;
    ack_en = 1'b0;
    req_hi = 0;
    frame_begin();
    spi_xfer(8'h81, 8'hA5, "to_miso0", 0);
    cycles(25);
    chk("to_nreq",  32'(nreq - b), 32'd1);
    chk("to_reqhi", 32'(req_hi),   32'd15);
    chk("to_req",   32'(bus_req),  32'h0);
    chk("to_err",   32'(err),      32'h1);
    spi_xfer(8'h00, 8'hEE, "to_miso1", 2);
    frame_end();
    ack_en = 1'b1;

    // Underrun: MISO byte requested before slow read data returns.
    ack_dly = 12;
    rd_val  = 8'h77;
    frame_begin();
    chk("ur_err_clr0", 32'(err), 32'h0);
    spi_xfer(8'h83, 8'hA5, "ur_miso0", 0);
    spi_xfer(8'h00, 8'hEE, "ur_miso1", 0);
    chk("ur_err", 32'(err), 32'h1);
    cycles(15);
    chk("ur_req_done", 32'(bus_req), 32'h0);
    frame_end();
    frame_begin();
    chk("ur_err_clr", 32'(err), 32'h0);
    frame_end();

    // Abort between command and data, then a normal write.
    b = nreq;
    ack_dly = 2;
    frame_begin();
    spi_xfer(8'h02, 8'hA5, "ab_miso0", 0);
    frame_end();
    chk("ab_nreq", 32'(nreq - b), 32'd0);
    chk("ab_req",  32'(bus_req),  32'h0);
    frame_begin();
    spi_xfer(8'h10, 8'hA5, "ab_miso1", 0);
    spi_xfer(8'h99, 8'hA5, "ab_miso2", 0);
    cycles(6);
    chk("ab_nreq2", 32'(nreq - b),     32'd1);
    chk("ab_we",    32'(log_we[b]),    32'h1);
    chk("ab_addr",  32'(log_addr[b]),  32'h10);
    chk("ab_wdata", 32'(log_wdata[b]), 32'h99);
    frame_end();

    // Reset during an outstanding read drops bus_req at the next edge.
    ack_en = 1'b0;
    frame_begin();
    spi_xfer(8'h81, 8'hA5, "rr_miso0", 0);
    cycles(3);
    chk("rr_req_hi", 32'(bus_req), 32'h1);
    rst  = 1'b1;
    ssel = 1'b1;
    cycles(1);
    chk("rr_req_lo", 32'(bus_req),    32'h0);
    chk("rr_miso",   32'(dataToSend), 32'h0000_00A5);
    rst = 1'b0;
    ack_en = 1'b1;
    cycles(4);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
